// File: rtl/uart_rx_ovs_if.sv
// Host-side receive port: holding register contents, per-frame flags and the valid/ready handshake.
interface uart_rx_ovs_if #(parameter int DATA_BITS = 8);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun;

    modport master (output rx_data, rx_valid, parity_err, frame_err, overrun, input rx_ready);
    modport slave  (input rx_data, rx_valid, parity_err, frame_err, overrun, output rx_ready);
endinterface

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver: 3-sample majority per bit, one-entry holding register with
// valid/ready handshake, parity/framing flags and an overrun pulse.
module uart_rx_ovs #(
    parameter int    DATA_BITS = 8,
    parameter int    OVS       = 16,
    parameter string PARITY    = "NONE",
    parameter int    STOP_BITS = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          baud_tick,
    input  logic          rx,
    uart_rx_ovs_if.master host
);
    localparam int CW = $clog2(OVS);
    localparam logic [CW-1:0] C_LO  = CW'(OVS/2 - 1);
    localparam logic [CW-1:0] C_MID = CW'(OVS/2);
    localparam logic [CW-1:0] C_DEC = CW'(OVS/2 + 1);
    localparam logic [CW-1:0] C_END = CW'(OVS - 1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam bit HAS_PAR = (PARITY != "NONE");
    localparam bit ODD     = (PARITY == "ODD");

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
    state_t state, state_n;

    logic [1:0]           sync;
    logic                 rx_s;
    logic [CW-1:0]        cnt;
    logic [3:0]           bitn;
    logic                 s_lo, s_mid, maj, at_dec, at_end, done;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr, ferr;

    // Sync flops reset high so leaving reset never looks like a start edge.
    always_ff @(posedge clk or posedge rst)
        if (rst) sync <= 2'b11;
        else     sync <= {sync[0], rx};
    assign rx_s = sync[1];

    assign maj    = (s_lo & s_mid) | (s_lo & rx_s) | (s_mid & rx_s);
    assign at_dec = baud_tick && (cnt == C_DEC);
    assign at_end = baud_tick && (cnt == C_END);

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_n;

    always_comb begin
        state_n = state;
        done    = 1'b0;
        unique case (state)
            IDLE:  if (baud_tick && !rx_s) state_n = START;
            START: if (at_dec && maj) state_n = IDLE;
                   else if (at_end) state_n = DATA;
            DATA:  if (at_end && bitn == LAST_DATA) state_n = HAS_PAR ? PAR : STOP;
            PAR:   if (at_end) state_n = STOP;
            // Complete mid-bit so the next start edge can be caught without waiting out the stop bit.
            STOP:  if (at_dec && (STOP_BITS == 1 || bitn == 4'd1)) begin
                       state_n = IDLE;
                       done    = 1'b1;
                   end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt   <= '0;
            bitn  <= '0;
            s_lo  <= 1'b1;
            s_mid <= 1'b1;
            shreg <= '0;
            perr  <= 1'b0;
            ferr  <= 1'b0;
        end else if (baud_tick) begin
            if (cnt == C_LO)  s_lo  <= rx_s;
            if (cnt == C_MID) s_mid <= rx_s;
            if (state_n == IDLE)    cnt <= '0;
            else if (state == IDLE) cnt <= CW'(1);
            else                    cnt <= (cnt == C_END) ? '0 : cnt + CW'(1);
            unique case (state)
                IDLE: begin
                    bitn <= '0;
                    perr <= 1'b0;
                    ferr <= 1'b0;
                end
                DATA: begin
                    if (at_dec) shreg <= {maj, shreg[DATA_BITS-1:1]};
                    if (at_end) bitn <= (bitn == LAST_DATA) ? 4'd0 : bitn + 4'd1;
                end
                PAR:  if (at_dec) perr <= ((^shreg) ^ maj) != ODD;
                STOP: begin
                    if (at_dec && !maj) ferr <= 1'b1;
                    if (at_end) bitn <= bitn + 4'd1;
                end
                default: ;
            endcase
        end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            host.rx_data    <= '0;
            host.rx_valid   <= 1'b0;
            host.parity_err <= 1'b0;
            host.frame_err  <= 1'b0;
            host.overrun    <= 1'b0;
        end else begin
            host.overrun <= 1'b0;
            if (done) begin
                if (!host.rx_valid || host.rx_ready) begin
                    host.rx_data    <= shreg;
                    host.rx_valid   <= 1'b1;
                    host.parity_err <= perr;
                    host.frame_err  <= ferr | ~maj;
                end else begin
                    host.overrun <= 1'b1;
                end
            end else if (host.rx_valid && host.rx_ready) begin
                host.rx_valid <= 1'b0;
            end
        end
endmodule
